// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for the load/store unit.
// The slave modport is the unit; master is the pipeline stage plus memory.
interface load_store_unit_if #(
    parameter int MEM_WIDTH = 15,
    parameter int MLEN      = 64
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;

    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_error;

    logic [2:0]           mem_funct3;
    logic [MEM_WIDTH-1:0] mem_rd_addr;
    logic [MLEN-1:0]      mem_rd_data;
    logic [MEM_WIDTH-1:0] mem_wr_addr;
    logic [MLEN-1:0]      mem_wr_data;
    logic                 mem_wr_en;
    logic                 mem_error;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_funct3, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en,
        output mem_rd_data, mem_error
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_funct3, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en,
        input  mem_rd_data, mem_error
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store front-end: validates a request, issues one aligned op or
// a run of byte ops to data memory, reassembles/extends loads, pulses a response.
module load_store_unit #(
    parameter int MEM_WIDTH      = 15,
    parameter int MLEN           = 64,
    parameter int MISALIGN_SPLIT = 1
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t state, state_nx;

    logic                 we_q, split_q, err_q;
    logic [2:0]           f3_q, k_q, cnt;
    logic [31:0]          wdata_q, acc;
    logic [MEM_WIDTH-1:0] addr_q;
    logic                 rd_vld;
    logic [1:0]           rd_idx;

    logic                 wr_en_q;
    logic [MEM_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [MLEN-1:0]      wr_data_q;
    logic [2:0]           mem_f3_q;

    logic                 accept, last_op, issue_now;
    logic                 f3_ok, mis, rng_err, pre_err, do_split;
    logic [2:0]           req_size;
    logic [MEM_WIDTH:0]   last_byte;

    logic [MEM_WIDTH-1:0] op_addr;
    logic [2:0]           op_idx, op_f3;
    logic                 op_we, op_split;
    logic [31:0]          op_wdata, ext_data;

    function automatic logic [MLEN-1:0] lane_data(input logic [31:0] d, input logic [1:0] idx,
                                                  input logic split, input logic [2:0] off);
        logic [MLEN-1:0] v;
        v = '0;
        if (split) v[7:0] = d[{idx, 3'b000} +: 8];
        else       v[31:0] = d;
        return v << {off, 3'b000};
    endfunction

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign last_op       = (cnt == k_q - 3'd1);

    // Request pre-check: funct3 legality, range (including the last byte of a split run), alignment
    always_comb begin
        if (bus.req_we) f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        else            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (bus.req_funct3[1:0])
            2'd0:    req_size = 3'd1;
            2'd1:    req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        mis       = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                    (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'b00);
        last_byte = {1'b0, bus.req_addr[MEM_WIDTH-1:0]} + (MEM_WIDTH+1)'(req_size - 3'd1);
        rng_err   = (|bus.req_addr[31:MEM_WIDTH]) || last_byte[MEM_WIDTH];
        do_split  = mis && (MISALIGN_SPLIT != 0);
        pre_err   = !f3_ok || rng_err || (mis && (MISALIGN_SPLIT == 0));
    end

    // Next op: the first comes straight from the request, later ones from the registered copy
    always_comb begin
        if (state == IDLE) begin
            op_addr  = bus.req_addr[MEM_WIDTH-1:0];
            op_idx   = 3'd0;
            op_we    = bus.req_we;
            op_split = do_split;
            op_f3    = bus.req_funct3;
            op_wdata = bus.req_wdata;
        end else begin
            op_addr  = addr_q + MEM_WIDTH'(1);
            op_idx   = cnt + 3'd1;
            op_we    = we_q;
            op_split = split_q;
            op_f3    = f3_q;
            op_wdata = wdata_q;
        end
        issue_now = (state == IDLE && accept && !pre_err) || (state == ISSUE && !last_op);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = pre_err ? RESP : ISSUE;
            ISSUE: if (last_op) state_nx = we_q ? RESP : DRAIN;
            DRAIN: state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= '0;
            k_q       <= '0;
            cnt       <= '0;
            wdata_q   <= '0;
            acc       <= '0;
            addr_q    <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            mem_f3_q  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                we_q    <= bus.req_we;
                split_q <= do_split;
                err_q   <= pre_err;
                f3_q    <= bus.req_funct3;
                k_q     <= do_split ? req_size : 3'd1;
                wdata_q <= bus.req_wdata;
                acc     <= '0;
            end
            if (state == ISSUE) err_q <= err_q | bus.mem_error;

            wr_en_q <= issue_now && op_we;
            if (issue_now) begin
                addr_q   <= op_addr;
                cnt      <= op_idx;
                mem_f3_q <= op_split ? (op_we ? 3'b000 : 3'b100) : op_f3;
                if (op_we) begin
                    wr_addr_q <= op_addr;
                    wr_data_q <= lane_data(op_wdata, op_idx[1:0], op_split, op_addr[2:0]);
                end else begin
                    rd_addr_q <= op_addr;
                end
            end

            // Read data lands one cycle after its address; track which byte it belongs to
            rd_vld <= (state == ISSUE) && !we_q;
            rd_idx <= cnt[1:0];
            if (rd_vld) begin
                if (split_q) acc[{rd_idx, 3'b000} +: 8] <= bus.mem_rd_data[7:0];
                else         acc <= bus.mem_rd_data[31:0];
            end
        end
    end

    always_comb begin
        case (f3_q)
            3'b000:  ext_data = {{24{acc[7]}}, acc[7:0]};
            3'b001:  ext_data = {{16{acc[15]}}, acc[15:0]};
            3'b100:  ext_data = {24'd0, acc[7:0]};
            3'b101:  ext_data = {16'd0, acc[15:0]};
            default: ext_data = acc;
        endcase
    end

    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_error   = (state == RESP) && err_q;
    assign bus.rsp_rdata   = (state == RESP && !we_q && !err_q) ? ext_data : 32'd0;

    // Gated so a reset landing mid-sequence cannot commit the in-flight byte
    assign bus.mem_wr_en   = wr_en_q && !rst;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.mem_funct3  = mem_f3_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: split-enabled unit against a byte-array memory, plus a
// no-split unit for misaligned-error behaviour.
module tb_load_store_unit;
    localparam int MW = 15;
    localparam int ML = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.MEM_WIDTH(MW), .MLEN(ML)) ifa ();
    load_store_unit_if #(.MEM_WIDTH(MW), .MLEN(ML)) ifb ();

    load_store_unit #(.MEM_WIDTH(MW), .MLEN(ML), .MISALIGN_SPLIT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    load_store_unit #(.MEM_WIDTH(MW), .MLEN(ML), .MISALIGN_SPLIT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int          sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    assign ifa.req_valid  = req_valid && (sel == 0);
    assign ifb.req_valid  = req_valid && (sel == 1);
    assign ifa.req_we     = req_we;
    assign ifb.req_we     = req_we;
    assign ifa.req_funct3 = req_funct3;
    assign ifb.req_funct3 = req_funct3;
    assign ifa.req_addr   = req_addr;
    assign ifb.req_addr   = req_addr;
    assign ifa.req_wdata  = req_wdata;
    assign ifb.req_wdata  = req_wdata;
    assign ifa.mem_error  = 1'b0;
    assign ifb.mem_error  = 1'b0;
    assign ifb.mem_rd_data = '0;

    logic          o_ready, o_rvalid, o_rerr, o_wr_en;
    logic [31:0]   o_rdata;
    logic [MW-1:0] o_rd_addr, o_wr_addr;
    logic [ML-1:0] o_wr_data;
    logic [2:0]    o_f3;
    assign o_ready   = sel == 1 ? ifb.req_ready   : ifa.req_ready;
    assign o_rvalid  = sel == 1 ? ifb.rsp_valid   : ifa.rsp_valid;
    assign o_rerr    = sel == 1 ? ifb.rsp_error   : ifa.rsp_error;
    assign o_rdata   = sel == 1 ? ifb.rsp_rdata   : ifa.rsp_rdata;
    assign o_wr_en   = sel == 1 ? ifb.mem_wr_en   : ifa.mem_wr_en;
    assign o_rd_addr = sel == 1 ? ifb.mem_rd_addr : ifa.mem_rd_addr;
    assign o_wr_addr = sel == 1 ? ifb.mem_wr_addr : ifa.mem_wr_addr;
    assign o_wr_data = sel == 1 ? ifb.mem_wr_data : ifa.mem_wr_data;
    assign o_f3      = sel == 1 ? ifb.mem_funct3  : ifa.mem_funct3;

    // Byte-addressed data memory for unit A: lane-positioned writes, right-justified reads
    logic [7:0]    mem [0:32767];
    logic [ML-1:0] rd_q;
    assign ifa.mem_rd_data = rd_q;

    always @(posedge clk) begin
        int sz;
        for (int j = 0; j < 8; j++) rd_q[8*j +: 8] <= mem[(int'(ifa.mem_rd_addr) + j) % 32768];
        case (ifa.mem_funct3[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            default: sz = 4;
        endcase
        if (ifa.mem_wr_en)
            for (int j = 0; j < sz; j++)
                if (int'(ifa.mem_wr_addr[2:0]) + j < 8)
                    mem[(int'(ifa.mem_wr_addr) + j) % 32768] <= ifa.mem_wr_data[8*(int'(ifa.mem_wr_addr[2:0]) + j) +: 8];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int            lat, nwr;
    logic [31:0]   r_data;
    logic          r_err;
    logic [ML-1:0] wlog_d [8];
    logic [MW-1:0] wlog_a [8];
    logic [2:0]    wlog_f [8];

    // One request; latency counted in cycles after the accept edge (N+1 = 1)
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nwr = 0; r_data = '0; r_err = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (o_wr_en) begin
                if (nwr < 8) begin
                    wlog_d[nwr] = o_wr_data; wlog_a[nwr] = o_wr_addr; wlog_f[nwr] = o_f3;
                end
                nwr++;
            end
            if (o_rvalid) begin
                lat = c; r_data = o_rdata; r_err = o_rerr;
            end
        end
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input int exp_lat, input logic [31:0] exp_data);
        run(1'b0, f3, addr, 32'd0);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(r_data), 64'(exp_data));
        chk({tag, "_err"}, 64'(r_err), 64'd0);
    endtask

    task automatic expect_err(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [MW-1:0] exp_rd_addr);
        run(we, f3, addr, 32'hCAFEF00D);
        chk({tag, "_lat"}, 64'(lat), 64'd1);
        chk({tag, "_err"}, 64'(r_err), 64'd1);
        chk({tag, "_data"}, 64'(r_data), 64'd0);
        chk({tag, "_nwr"}, 64'(nwr), 64'd0);
        chk({tag, "_rdaddr"}, 64'(o_rd_addr), 64'(exp_rd_addr));
    endtask

    initial begin
        int seen;
        sel = 0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ifa.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
        chk("rst_wr_en", 64'(ifa.mem_wr_en), 64'd0);
        chk("rst_wr_data", ifa.mem_wr_data, 64'd0);
        chk("rst_rd_addr", 64'(ifa.mem_rd_addr), 64'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 64'(ifa.req_ready), 64'd1);

        // Aligned word store and loads
        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw10_lat", 64'(lat), 64'd2);
        chk("sw10_nwr", 64'(nwr), 64'd1);
        chk("sw10_wdata", 64'(wlog_d[0][31:0]), 64'hDEADBEEF);
        chk("sw10_err", 64'(r_err), 64'd0);
        load("lw10", 3'b010, 32'h10, 3, 32'hDEADBEEF);
        load("lb13", 3'b000, 32'h13, 3, 32'hFFFFFFDE);
        load("lbu13", 3'b100, 32'h13, 3, 32'h000000DE);

        // Halfword extension in the upper lanes
        run(1'b1, 3'b010, 32'h14, 32'h8001ABCD);
        chk("sw14_wdata_hi", 64'(wlog_d[0][63:32]), 64'h8001ABCD);
        chk("sw14_lat", 64'(lat), 64'd2);
        load("lh16", 3'b001, 32'h16, 3, 32'hFFFF8001);
        load("lhu16", 3'b101, 32'h16, 3, 32'h00008001);
        load("lh14", 3'b001, 32'h14, 3, 32'hFFFFABCD);

        // Misaligned word split into four byte ops
        run(1'b1, 3'b010, 32'h0D, 32'h11223344);
        chk("ssw_nwr", 64'(nwr), 64'd4);
        chk("ssw_lat", 64'(lat), 64'd5);
        chk("ssw_d0", wlog_d[0], 64'h0000_4400_0000_0000);
        chk("ssw_d1", wlog_d[1], 64'h0033_0000_0000_0000);
        chk("ssw_d2", wlog_d[2], 64'h2200_0000_0000_0000);
        chk("ssw_d3", wlog_d[3], 64'h0000_0000_0000_0011);
        chk("ssw_a0", 64'(wlog_a[0]), 64'h0D);
        chk("ssw_a3", 64'(wlog_a[3]), 64'h10);
        chk("ssw_f0", 64'(wlog_f[0]), 64'd0);
        chk("ssw_f3", 64'(wlog_f[3]), 64'd0);
        load("slw0d", 3'b010, 32'h0D, 6, 32'h11223344);

        // Illegal requests: no memory activity, read address keeps its last value
        expect_err("ld_f3_011", 1'b0, 3'b011, 32'h20, 15'h10);
        expect_err("st_f3_100", 1'b1, 3'b100, 32'h20, 15'h10);
        expect_err("lw_range", 1'b0, 3'b010, 32'h0001_0000, 15'h10);
        run(1'b1, 3'b000, 32'h7FFF, 32'h00000080);
        chk("sb7fff_err", 64'(r_err), 64'd0);
        chk("sb7fff_wdata", wlog_d[0], 64'h8000_0000_0000_0000);
        load("lb7fff", 3'b000, 32'h7FFF, 3, 32'hFFFFFF80);

        // No-split unit reports misaligned accesses as errors
        sel = 1;
        expect_err("b_lw02", 1'b0, 3'b010, 32'h02, 15'h0);
        expect_err("b_sh07", 1'b1, 3'b001, 32'h07, 15'h0);
        chk("b_wr_addr", 64'(o_wr_addr), 64'd0);
        sel = 0;

        // Reset during the third op of a split store
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0D; req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(ifa.req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
        chk("mid_rst_wr_en", 64'(ifa.mem_wr_en), 64'd0);
        chk("mid_rst_wr_addr", 64'(ifa.mem_wr_addr), 64'd0);
        chk("mid_rst_wr_data", ifa.mem_wr_data, 64'd0);
        chk("mid_rst_funct3", 64'(ifa.mem_funct3), 64'd0);
        chk("mid_rst_rdata", 64'(ifa.rsp_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rst_ready_rel", 64'(ifa.req_ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 64'(seen), 64'd0);
        load("lw0d_after_rst", 3'b010, 32'h0D, 6, 32'h1122C3D4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
